// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: operand/result bundle between the decoder-side sequencer
// and alu_seq_unit.
//   master (sequencer): drives start, mode, d, r, s, op1w; reads busy, done,
//                       R, S, resw
//   slave  (ALU)      : the reverse
// WIDTH must match the WIDTH of the alu_seq_unit instance it connects to.
interface alu_seq_unit_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic [4:0]           mode;
    logic [WIDTH-1:0]     d;
    logic [WIDTH-1:0]     r;
    logic [7:0]           s;
    logic [2*WIDTH-1:0]   op1w;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     R;
    logic [7:0]           S;
    logic [2*WIDTH-1:0]   resw;

    modport master (output start, mode, d, r, s, op1w,
                    input  busy, done, R, S, resw);
    modport slave  (input  start, mode, d, r, s, op1w,
                    output busy, done, R, S, resw);
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with the core's op/flag set on a WIDTH-bit
// datapath. Single-cycle ops post their result one clock after start;
// MUL/MULS/MULSU run a WIDTH-clock shift-add engine while busy is high.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : start/mode/d/r/s/op1w in; busy/done/R/S/resw out.
//                  R, S, resw hold their value until the next done pulse.
// Optional build macro ALU_FMUL_EN: adds FMUL/FMULS/FMULSU (modes 26..28),
// run on the multiply engine with a final left shift of the product.
module alu_seq_unit #(
    parameter int WIDTH = 8
) (
    input logic         clock,
    input logic         reset,
    alu_seq_unit_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam int W2  = 2 * WIDTH;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;
    // SREG bit positions {I,T,H,S,V,N,Z,C}
    localparam int C_B = 0, Z_B = 1, N_B = 2, V_B = 3, S_B = 4, H_B = 5, T_B = 6;

    localparam logic [4:0] M_LDI = 5'd0,  M_CPC = 5'd1,  M_SBC = 5'd2,  M_ADD = 5'd3,
                           M_CP  = 5'd5,  M_SUB = 5'd6,  M_ADC = 5'd7,  M_AND = 5'd8,
                           M_EOR = 5'd9,  M_OR  = 5'd10, M_SREG = 5'd11, M_COM = 5'd12,
                           M_NEG = 5'd13, M_SWAP = 5'd14, M_INC = 5'd15, M_ASR = 5'd16,
                           M_LSR = 5'd17, M_ROR = 5'd18, M_DEC = 5'd19, M_ADIW = 5'd20,
                           M_SBIW = 5'd21, M_BLD = 5'd22, M_MUL = 5'd23, M_MULS = 5'd24,
                           M_MULSU = 5'd25;
`ifdef ALU_FMUL_EN
    localparam logic [4:0] M_FMUL = 5'd26, M_FMULS = 5'd27, M_FMULSU = 5'd28;
`endif

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [7:0]         s_q, s_d;
    logic [W2-1:0]      resw_q, resw_d;
    // multiply engine: magnitudes are multiplied, sign is applied at the end
    logic [W2-1:0]      mcand_q, mcand_d, acc_q, acc_d, acc_sum, prod, mul_res;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [7:0]         sreg_q, sreg_d;
`ifdef ALU_FMUL_EN
    logic               frac_q, frac_d, is_frac;
`endif

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0]   op_a, op_b, res, alu_r, d_mag, r_mag;
    logic [WIDTH:0]     sum, diff;
    logic               cin, h_add, h_sub, v_add, v_sub, upd_nz, z_chain, shin;
    logic [W2-1:0]      wsum, wdiff, alu_resw;
    logic [7:0]         alu_s, bmask;
    logic               is_mul, d_signed, r_signed, d_neg, r_neg;

    always_comb begin : alu_operands
        op_a = bus.d;
        op_b = bus.r;
        cin  = 1'b0;
        case (bus.mode)
            M_ADC, M_SBC, M_CPC: cin = bus.s[C_B];
            M_NEG: begin op_a = '0; op_b = bus.d; end
            default: ;
        endcase
        sum   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        diff  = {1'b0, op_a} - {1'b0, op_b} - {{WIDTH{1'b0}}, cin};
        h_add = (op_a[3] & op_b[3]) | (op_b[3] & ~sum[3]) | (~sum[3] & op_a[3]);
        h_sub = (~op_a[3] & op_b[3]) | (op_b[3] & diff[3]) | (diff[3] & ~op_a[3]);
        v_add = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
        v_sub = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
        wsum  = bus.op1w + {{WIDTH{1'b0}}, bus.r};
        wdiff = bus.op1w - {{WIDTH{1'b0}}, bus.r};
        shin  = (bus.mode == M_ASR) ? bus.d[MSB] :
                (bus.mode == M_ROR) ? bus.s[C_B] : 1'b0;
    end

    always_comb begin : alu_result
        alu_r    = r_q;
        alu_s    = bus.s;
        alu_resw = resw_q;
        res      = '0;
        upd_nz   = 1'b0;
        z_chain  = 1'b0;
        bmask    = 8'b1 << bus.r[2:0];
        case (bus.mode)
            M_LDI: alu_r = bus.r;
            M_ADD, M_ADC: begin
                res = sum[MSB:0]; upd_nz = 1'b1;
                alu_s[H_B] = h_add; alu_s[V_B] = v_add; alu_s[C_B] = sum[WIDTH];
            end
            M_CP, M_SUB, M_NEG, M_CPC, M_SBC: begin
                res = diff[MSB:0]; upd_nz = 1'b1;
                z_chain = (bus.mode == M_CPC) || (bus.mode == M_SBC);
                alu_s[H_B] = h_sub; alu_s[V_B] = v_sub; alu_s[C_B] = diff[WIDTH];
            end
            M_AND: begin res = bus.d & bus.r; upd_nz = 1'b1; alu_s[V_B] = 1'b0; end
            M_EOR: begin res = bus.d ^ bus.r; upd_nz = 1'b1; alu_s[V_B] = 1'b0; end
            M_OR:  begin res = bus.d | bus.r; upd_nz = 1'b1; alu_s[V_B] = 1'b0; end
            M_SREG: alu_s = bus.r[7:0];
            M_COM: begin
                res = ~bus.d; upd_nz = 1'b1; alu_s[C_B] = 1'b1; alu_s[V_B] = 1'b0;
            end
            M_SWAP: begin
                alu_r      = bus.d;
                alu_r[7:0] = {bus.d[3:0], bus.d[7:4]};
            end
            M_INC: begin res = bus.d + ONE; upd_nz = 1'b1; alu_s[V_B] = (res == MIN_NEG); end
            M_DEC: begin res = bus.d - ONE; upd_nz = 1'b1; alu_s[V_B] = (res == MAX_POS); end
            M_ASR, M_LSR, M_ROR: begin
                res = {shin, bus.d[MSB:1]}; upd_nz = 1'b1;
                alu_s[C_B] = bus.d[0];
                alu_s[V_B] = shin ^ bus.d[0];   // N ^ C, N being the shifted-in bit
            end
            M_ADIW: begin
                alu_resw   = wsum;
                alu_s[N_B] = wsum[W2-1];
                alu_s[Z_B] = (wsum == '0);
                alu_s[V_B] = ~bus.op1w[W2-1] & wsum[W2-1];
                alu_s[C_B] = ~wsum[W2-1] & bus.op1w[W2-1];
                alu_s[S_B] = wsum[W2-1] ^ alu_s[V_B];
            end
            M_SBIW: begin
                alu_resw   = wdiff;
                alu_s[N_B] = wdiff[W2-1];
                alu_s[Z_B] = (wdiff == '0);
                alu_s[V_B] = bus.op1w[W2-1] & ~wdiff[W2-1];
                alu_s[C_B] = wdiff[W2-1] & ~bus.op1w[W2-1];
                alu_s[S_B] = wdiff[W2-1] ^ alu_s[V_B];
            end
            M_BLD: begin
                alu_r      = bus.d;
                alu_r[7:0] = bus.s[T_B] ? (bus.d[7:0] | bmask) : (bus.d[7:0] & ~bmask);
            end
            default: alu_r = '1;
        endcase
        if (upd_nz) begin
            alu_r      = res;
            alu_s[N_B] = res[MSB];
            // carry-chained compares only keep Z if it was already set
            alu_s[Z_B] = (res == '0) & (~z_chain | bus.s[Z_B]);
            alu_s[S_B] = res[MSB] ^ alu_s[V_B];
        end
    end

    // ---------------- multiply decode ----------------
    always_comb begin : mul_decode
        is_mul   = 1'b0;
        d_signed = 1'b0;
        r_signed = 1'b0;
`ifdef ALU_FMUL_EN
        is_frac  = 1'b0;
`endif
        case (bus.mode)
            M_MUL:   is_mul = 1'b1;
            M_MULS:  begin is_mul = 1'b1; d_signed = 1'b1; r_signed = 1'b1; end
            M_MULSU: begin is_mul = 1'b1; d_signed = 1'b1; end
`ifdef ALU_FMUL_EN
            M_FMUL:   begin is_mul = 1'b1; is_frac = 1'b1; end
            M_FMULS:  begin is_mul = 1'b1; is_frac = 1'b1; d_signed = 1'b1; r_signed = 1'b1; end
            M_FMULSU: begin is_mul = 1'b1; is_frac = 1'b1; d_signed = 1'b1; end
`endif
            default: ;
        endcase
        d_neg = d_signed & bus.d[MSB];
        r_neg = r_signed & bus.r[MSB];
        d_mag = d_neg ? (~bus.d + ONE) : bus.d;
        r_mag = r_neg ? (~bus.r + ONE) : bus.r;
    end

    // ---------------- FSM ----------------
    always_comb begin : fsm_next
        state_d = state_q;
        done_d  = 1'b0;
        r_d     = r_q;
        s_d     = s_q;
        resw_d  = resw_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        sreg_d  = sreg_q;
`ifdef ALU_FMUL_EN
        frac_d  = frac_q;
`endif
        acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
        prod    = sign_q ? (~acc_sum + W2'(1)) : acc_sum;
        mul_res = prod;
`ifdef ALU_FMUL_EN
        if (frac_q) mul_res = {prod[W2-2:0], 1'b0};
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                if (is_mul) begin
                    mcand_d = {{WIDTH{1'b0}}, d_mag};
                    mplr_d  = r_mag;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    sign_d  = d_neg ^ r_neg;
                    sreg_d  = bus.s;
`ifdef ALU_FMUL_EN
                    frac_d  = is_frac;
`endif
                    state_d = MUL;
                end else begin
                    r_d    = alu_r;
                    s_d    = alu_s;
                    resw_d = alu_resw;
                    done_d = 1'b1;
                end
            end
            MUL: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    // last step: this clock's partial sum is the full product
                    resw_d     = mul_res;
                    s_d        = sreg_q;
                    s_d[C_B]   = prod[W2-1];
                    s_d[Z_B]   = (mul_res == '0);
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            r_q     <= '0;
            s_q     <= '0;
            resw_q  <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            sreg_q  <= '0;
`ifdef ALU_FMUL_EN
            frac_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            r_q     <= r_d;
            s_q     <= s_d;
            resw_q  <= resw_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            sreg_q  <= sreg_d;
`ifdef ALU_FMUL_EN
            frac_q  <= frac_d;
`endif
        end
    end

    assign bus.busy = (state_q == MUL);
    assign bus.done = done_q;
    assign bus.R    = r_q;
    assign bus.S    = s_q;
    assign bus.resw = resw_q;
endmodule
